// File: rtl/screen_writer.sv
// Character-cell write engine: turns host register strobes into screen RAM writes
// at the text cursor, and runs a whole-screen fill sweep on command.
module screen_writer #(
    parameter int COLS = 80,
    parameter int ROWS = 60,
    parameter int AW   = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          reg_we,
    input  logic [3:0]    reg_addr,
    input  logic [7:0]    reg_wdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    output logic          busy,
    output logic          overrun,
    output logic [6:0]    cursor_x,
    output logic [5:0]    cursor_y
);

    localparam logic [0:0]    ST_IDLE = 1'b0;
    localparam logic [0:0]    ST_FILL = 1'b1;
    localparam logic [3:0]    A_DATA  = 4'd1;
    localparam logic [3:0]    A_CURX  = 4'd2;
    localparam logic [3:0]    A_CURY  = 4'd3;
    localparam logic [3:0]    A_FILL  = 4'd5;
    localparam logic [3:0]    A_CTRL  = 4'd6;
    localparam logic [6:0]    X_MAX   = 7'(COLS - 1);
    localparam logic [5:0]    Y_MAX   = 6'(ROWS - 1);
    localparam logic [AW-1:0] LAST    = AW'(COLS * ROWS - 1);
    localparam logic [AW-1:0] COLS_W  = AW'(COLS);

    logic [0:0]    state_r;
    logic          ram_we_r;
    logic [AW-1:0] ram_addr_r;
    logic [7:0]    ram_wdata_r;
    logic [7:0]    fill_char_r;
    logic          autoinc_r;
    logic          overrun_r;
    logic [6:0]    cursor_x_r;
    logic [5:0]    cursor_y_r;

    logic          wr_data_s;
    logic          wr_curx_s;
    logic          wr_cury_s;
    logic          wr_fill_s;
    logic          wr_ctrl_s;
    logic          x_ok_s;
    logic          y_ok_s;
    logic          drop_s;
    logic [AW-1:0] cell_addr_s;
    logic [6:0]    next_x_s;
    logic [5:0]    next_y_s;

    // Register decode, cursor advance and linear cell address.
    always_comb begin
        wr_data_s   = reg_we && (reg_addr == A_DATA);
        wr_curx_s   = reg_we && (reg_addr == A_CURX);
        wr_cury_s   = reg_we && (reg_addr == A_CURY);
        wr_fill_s   = reg_we && (reg_addr == A_FILL);
        wr_ctrl_s   = reg_we && (reg_addr == A_CTRL);
        x_ok_s      = ({24'd0, reg_wdata} < 32'(COLS));
        y_ok_s      = ({24'd0, reg_wdata} < 32'(ROWS));
        drop_s      = (state_r == ST_FILL) && (wr_data_s || wr_curx_s || wr_cury_s || wr_fill_s);
        cell_addr_s = AW'(cursor_y_r) * COLS_W + AW'(cursor_x_r);
        next_x_s    = 7'd0;
        next_y_s    = 6'd0;
        if (cursor_x_r != X_MAX) begin
            next_x_s = cursor_x_r + 7'd1;
            next_y_s = cursor_y_r;
        end else if (cursor_y_r != Y_MAX) begin
            next_x_s = 7'd0;
            next_y_s = cursor_y_r + 6'd1;
        end else begin
            next_x_s = 7'd0;
            next_y_s = 6'd0;
        end
    end

    // Main state: host command servicing, fill sweep, control and overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= '0;
            ram_wdata_r <= 8'd0;
            fill_char_r <= 8'd0;
            autoinc_r   <= 1'b1;
            overrun_r   <= 1'b0;
            cursor_x_r  <= 7'd0;
            cursor_y_r  <= 6'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ram_we_r <= 1'b0;
                    if (wr_data_s) begin
                        ram_we_r    <= 1'b1;
                        ram_addr_r  <= cell_addr_s;
                        ram_wdata_r <= reg_wdata;
                        if (autoinc_r) begin
                            cursor_x_r <= next_x_s;
                            cursor_y_r <= next_y_s;
                        end
                    end else if (wr_curx_s && x_ok_s) begin
                        cursor_x_r <= reg_wdata[6:0];
                    end else if (wr_cury_s && y_ok_s) begin
                        cursor_y_r <= reg_wdata[5:0];
                    end else if (wr_fill_s) begin
                        // The first sweep write is issued on the command edge itself.
                        state_r     <= ST_FILL;
                        fill_char_r <= reg_wdata;
                        ram_we_r    <= 1'b1;
                        ram_addr_r  <= '0;
                        ram_wdata_r <= reg_wdata;
                    end
                end
                ST_FILL: begin
                    if (ram_addr_r == LAST) begin
                        state_r    <= ST_IDLE;
                        ram_we_r   <= 1'b0;
                        cursor_x_r <= 7'd0;
                        cursor_y_r <= 6'd0;
                    end else begin
                        ram_we_r    <= 1'b1;
                        ram_addr_r  <= ram_addr_r + AW'(1);
                        ram_wdata_r <= fill_char_r;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    ram_we_r <= 1'b0;
                end
            endcase
            if (wr_ctrl_s) begin
                autoinc_r <= reg_wdata[0];
            end
            // A drop in the same cycle as a clear wins.
            overrun_r <= (overrun_r && !(wr_ctrl_s && reg_wdata[7])) || drop_s;
        end
    end

    assign ram_we    = ram_we_r;
    assign ram_addr  = ram_addr_r;
    assign ram_wdata = ram_wdata_r;
    assign busy      = (state_r == ST_FILL);
    assign overrun   = overrun_r;
    assign cursor_x  = cursor_x_r;
    assign cursor_y  = cursor_y_r;

endmodule

// File: tb/tb_screen_writer.sv
// Self-checking bench for screen_writer: linear-cursor reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_screen_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int AW    = 13;
    localparam int TOTAL = COLS * ROWS;

    logic          clk = 1'b0;
    logic          rst;
    logic          reg_we;
    logic [3:0]    reg_addr;
    logic [7:0]    reg_wdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic          busy;
    logic          overrun;
    logic [6:0]    cursor_x;
    logic [5:0]    cursor_y;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model: cursor kept as a linear cell index.
    int   m_pos   = 0;
    bit   m_auto  = 1'b1;
    bit   m_over  = 1'b0;
    bit   m_fill  = 1'b0;
    int   m_next  = 0;
    int   m_char  = 0;
    bit   e_we    = 1'b0;
    int   e_addr  = 0;
    int   e_data  = 0;

    screen_writer #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
        .clk(clk), .rst(rst), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .busy(busy),
        .overrun(overrun), .cursor_x(cursor_x), .cursor_y(cursor_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each active edge from the inputs the DUT also samples.
    always @(posedge clk) begin : model
        bit drop;
        drop = 1'b0;
        if (rst) begin
            m_pos = 0; m_auto = 1'b1; m_over = 1'b0; m_fill = 1'b0; m_next = 0; m_char = 0;
            e_we = 1'b0; e_addr = 0; e_data = 0;
        end else begin
            if (m_fill) begin
                if (m_next == TOTAL) begin
                    m_fill = 1'b0;
                    m_pos  = 0;
                    e_we   = 1'b0;
                end else begin
                    e_we   = 1'b1;
                    e_addr = m_next;
                    e_data = m_char;
                    m_next = m_next + 1;
                end
                if (reg_we && (reg_addr == 4'd1 || reg_addr == 4'd2 || reg_addr == 4'd3 || reg_addr == 4'd5))
                    drop = 1'b1;
            end else begin
                e_we = 1'b0;
                if (reg_we) begin
                    case (reg_addr)
                        4'd1: begin
                            e_we = 1'b1; e_addr = m_pos; e_data = int'(reg_wdata);
                            if (m_auto) m_pos = (m_pos + 1) % TOTAL;
                        end
                        4'd2: if (int'(reg_wdata) < COLS) m_pos = (m_pos / COLS) * COLS + int'(reg_wdata);
                        4'd3: if (int'(reg_wdata) < ROWS) m_pos = int'(reg_wdata) * COLS + (m_pos % COLS);
                        4'd5: begin
                            m_fill = 1'b1; m_char = int'(reg_wdata);
                            e_we = 1'b1; e_addr = 0; e_data = m_char; m_next = 1;
                        end
                        default: ;
                    endcase
                end
            end
            if (reg_we && reg_addr == 4'd6) begin
                m_auto = reg_wdata[0];
                if (reg_wdata[7]) m_over = 1'b0;
            end
            if (drop) m_over = 1'b1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ram_we", int'(ram_we), int'(e_we));
            check("ram_addr", int'(ram_addr), e_addr);
            check("ram_wdata", int'(ram_wdata), e_data);
            check("busy", int'(busy), int'(m_fill));
            check("overrun", int'(overrun), int'(m_over));
            check("cursor_x", int'(cursor_x), m_pos % COLS);
            check("cursor_y", int'(cursor_y), m_pos / COLS);
        end
    end

    // One-cycle strobe; call just after a falling edge, returns at the next one.
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        @(negedge clk);
        reg_we = 1'b0;
    endtask

    initial begin
        int bc;
        int k;
        bit done;
        int r;
        rst = 1'b1; reg_we = 1'b0; reg_addr = 4'd0; reg_wdata = 8'd0;
        @(negedge clk); @(negedge clk);
        chk_en = 1'b1;
        check("rst_we", int'(ram_we), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_addr", int'(ram_addr), 0);
        check("rst_cur", int'(cursor_x) + int'(cursor_y), 0);
        rst = 1'b0;
        @(negedge clk);

        wr(4'd1, 8'h41);
        check("d41_we", int'(ram_we), 1);
        check("d41_addr", int'(ram_addr), 0);
        check("d41_data", int'(ram_wdata), 8'h41);
        check("d41_x", int'(cursor_x), 1);
        @(negedge clk);
        check("d41_pulse", int'(ram_we), 0);

        wr(4'd2, 8'd79); wr(4'd3, 8'd59);
        wr(4'd1, 8'h5A);
        check("corner_addr", int'(ram_addr), 4799);
        wr(4'd1, 8'h5B);
        check("wrap_addr", int'(ram_addr), 0);
        check("wrap_we", int'(ram_we), 1);
        check("wrap_x", int'(cursor_x), 1);
        check("wrap_y", int'(cursor_y), 0);

        wr(4'd2, 8'd5); wr(4'd2, 8'd80);
        check("curx_bad", int'(cursor_x), 5);
        wr(4'd6, 8'h00);
        wr(4'd1, 8'h61);
        check("noinc_a1", int'(ram_addr), 5);
        wr(4'd1, 8'h62);
        check("noinc_a2", int'(ram_addr), 5);
        check("noinc_x", int'(cursor_x), 5);
        wr(4'd6, 8'h01);

        wr(4'd5, 8'h20);
        check("fill_busy", int'(busy), 1);
        bc = 1; k = 0; done = 1'b0;
        while (!done && k < 6000) begin
            if (k == 50) begin
                reg_we = 1'b1; reg_addr = 4'd1; reg_wdata = 8'h33;
            end
            @(negedge clk);
            reg_we = 1'b0;
            k++;
            if (busy) bc++;
            else done = 1'b1;
        end
        check("fill_len", bc, TOTAL);
        check("fill_ovr", int'(overrun), 1);
        check("fill_last_addr", int'(ram_addr), 4799);
        check("fill_cur", int'(cursor_x) + int'(cursor_y), 0);
        wr(4'd1, 8'h44);
        check("post_fill_addr", int'(ram_addr), 0);
        check("post_fill_we", int'(ram_we), 1);
        wr(4'd6, 8'h81);
        check("ovr_clr", int'(overrun), 0);
        wr(4'd1, 8'h45);
        check("auto_back_x", int'(cursor_x), 2);

        wr(4'd5, 8'h2E);
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_we", int'(ram_we), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_x", int'(cursor_x), 0);
        repeat (3) @(negedge clk);
        wr(4'd1, 8'h77);
        check("rst_mid_data", int'(ram_addr), 0);

        for (int i = 0; i < 12000; i++) begin
            rst    = ($urandom_range(0, 699) == 0);
            reg_we = ($urandom_range(0, 2) == 0);
            r      = int'($urandom_range(0, 299));
            if (r < 130)      begin reg_addr = 4'd1; reg_wdata = 8'($urandom); end
            else if (r < 175) begin reg_addr = 4'd2; reg_wdata = 8'($urandom_range(0, 90)); end
            else if (r < 220) begin reg_addr = 4'd3; reg_wdata = 8'($urandom_range(0, 65)); end
            else if (r < 260) begin reg_addr = 4'd6; reg_wdata = 8'($urandom); end
            else if (r < 262) begin reg_addr = 4'd5; reg_wdata = 8'($urandom); end
            else              begin reg_addr = 4'($urandom); reg_wdata = 8'($urandom); end
            @(negedge clk);
        end
        rst = 1'b0; reg_we = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
